// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first,
// repeating it rpt+1 times with gap idle cycles between copies.
module moore_seq_gen #(
    parameter int             WIDTH   = 4,
    parameter int             RPT_W   = 4,
    parameter int             GAP_W   = 4,
    parameter logic [WIDTH-1:0] DEF_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [WIDTH-1:0] pattern,
    input  logic [RPT_W-1:0] rpt,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sel_pat, sel_n;
    logic [IW-1:0]    bit_idx, idx_n;
    logic [RPT_W-1:0] rpt_left, rpt_n;
    logic [GAP_W-1:0] gap_len, glen_n;
    logic [GAP_W-1:0] gap_cnt, gcnt_n;
    logic             out_n, valid_n, busy_n, done_n;

    always_comb begin
        state_n = state;
        sel_n   = sel_pat;
        idx_n   = bit_idx;
        rpt_n   = rpt_left;
        glen_n  = gap_len;
        gcnt_n  = gap_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sel_n   = use_def ? DEF_PAT : pattern;
                    rpt_n   = rpt;
                    glen_n  = gap;
                    idx_n   = LAST;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx != '0) begin
                    idx_n = bit_idx - IW'(1);
                end else if (rpt_left != '0) begin
                    rpt_n = rpt_left - RPT_W'(1);
                    idx_n = LAST;
                    if (gap_len != '0) begin
                        gcnt_n  = gap_len - GAP_W'(1);
                        state_n = GAP;
                    end
                end else begin
                    state_n = DONE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_n = SHIFT;
                else gcnt_n = gap_cnt - GAP_W'(1);
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        valid_n = (state_n == SHIFT);
        out_n   = valid_n & sel_n[idx_n];
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_pat  <= '0;
            bit_idx  <= '0;
            rpt_left <= '0;
            gap_len  <= '0;
            gap_cnt  <= '0;
            out      <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            sel_pat  <= sel_n;
            bit_idx  <= idx_n;
            rpt_left <= rpt_n;
            gap_len  <= glen_n;
            gap_cnt  <= gcnt_n;
            out      <= out_n;
            valid    <= valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: queue-based transmission model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_moore_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       use_def = 1'b0;
    logic [3:0] pattern = 4'b0;
    logic [3:0] rpt = 4'b0;
    logic [3:0] gap = 4'b0;
    logic       out, valid, busy, done;

    moore_seq_gen dut (
        .clk(clk), .rst(rst), .start(start), .use_def(use_def),
        .pattern(pattern), .rpt(rpt), .gap(gap),
        .out(out), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic o;
        logic v;
        logic b;
        logic d;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt, done_cnt;
    logic [31:0] ohist, vhist;

    task automatic chk(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got %b want %b", nm, $time, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    // Whole transmission expanded into a per-cycle list of outputs.
    task automatic build(input logic [3:0] p, input int r, input int g);
        for (int c = 0; c <= r; c++) begin
            for (int b = 3; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
            if (c < r)
                for (int k = 0; k < g; k++) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
    endtask

    task automatic model_edge();
        if (rst) begin
            q.delete();
            cur = '0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.b && start) begin
            build(use_def ? 4'b1011 : pattern, int'(rpt), int'(gap));
            cur = q.pop_front();
        end else begin
            cur = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out", out, cur.o);
        chk("valid", valid, cur.v);
        chk("busy", busy, cur.b);
        chk("done", done, cur.d);
        if (busy === 1'b1) begin
            busy_cnt++;
            ohist = {ohist[30:0], out};
            vhist = {vhist[30:0], valid};
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic clr();
        busy_cnt = 0;
        done_cnt = 0;
        ohist = '0;
        vhist = '0;
    endtask

    initial begin
        clr();
        repeat (2) step();
        rst = 1'b0;

        // default pattern, single copy
        clr();
        use_def = 1'b1; rpt = 4'd0; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk_int("t1_busy", busy_cnt, 5);
        chk_int("t1_done", done_cnt, 1);
        chk_int("t1_out", int'(ohist[4:0]), 5'b10110);
        chk_int("t1_valid", int'(vhist[4:0]), 5'b11110);

        // user pattern, two copies, gap of 2
        clr();
        use_def = 1'b0; pattern = 4'b0110; rpt = 4'd1; gap = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        chk_int("t2_busy", busy_cnt, 11);
        chk_int("t2_done", done_cnt, 1);
        chk_int("t2_out", int'(ohist[10:0]), 11'b01100001100);
        chk_int("t2_valid", int'(vhist[10:0]), 11'b11110011110);

        // back-to-back default copies
        clr();
        use_def = 1'b1; rpt = 4'd1; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        chk_int("t3_busy", busy_cnt, 9);
        chk_int("t3_out", int'(ohist[8:0]), 9'b101110110);

        // start re-pulsed mid-stream with different inputs
        clr();
        use_def = 1'b0; pattern = 4'b1100; rpt = 4'd1; gap = 4'd3;
        start = 1'b1;
        step();
        for (int i = 1; i < 16; i++) begin
            start = (i == 2 || i == 6);
            pattern = 4'b0011;
            use_def = 1'b1;
            rpt = 4'd5;
            gap = 4'd0;
            step();
        end
        start = 1'b0;
        chk_int("t4_busy", busy_cnt, 12);
        chk_int("t4_done", done_cnt, 1);
        chk_int("t4_out", int'(ohist[11:0]), 12'b110000011000);

        // reset during third bit
        clr();
        use_def = 1'b1; rpt = 4'd0; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_int("t5_busy", busy_cnt, 3);
        chk_int("t5_done", done_cnt, 0);
        clr();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk_int("t5b_busy", busy_cnt, 5);
        chk_int("t5b_out", int'(ohist[4:0]), 5'b10110);

        // maximum repeat and gap
        clr();
        use_def = 1'b0; pattern = 4'b1001; rpt = 4'hF; gap = 4'hF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (295) step();
        chk_int("t6_busy", busy_cnt, 290);
        chk_int("t6_done", done_cnt, 1);

        // random traffic, inputs churn every cycle
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4 == 0);
            use_def = $urandom % 2;
            pattern = 4'($urandom);
            rpt = ($urandom % 10 == 0) ? 4'hF : 4'($urandom % 3);
            gap = ($urandom % 10 == 0) ? 4'hF : 4'($urandom % 3);
            rst = ($urandom % 150 == 0);
            step();
        end
        rst = 1'b0;
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/moore_seq_gen.md
Name: moore_seq_gen

Overview:
- Serial bit-pattern transmitter: the driving end for the Moore sequence detectors in the FSM set.
- Latches a WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable idle gap between copies.
- Replaces hand-written per-cycle `in` stimulus in detector benches; also usable as an on-chip pattern source.

Parameters:
- WIDTH, 4, pattern length in bits (>=2)
- RPT_W, 4, width of repeat-count input
- GAP_W, 4, width of inter-pattern gap input
- DEF_PAT, 4'b1011, pattern driven when use_def=1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin a transmission; sampled only in IDLE
- use_def  input  1  1 = send DEF_PAT, 0 = send pattern
- pattern  input  WIDTH  user pattern, MSB sent first
- rpt  input  RPT_W  extra copies; total copies = rpt+1
- gap  input  GAP_W  zero cycles inserted between copies
- out  output  1  serial data bit (registered)
- valid  output  1  high while out carries a pattern bit
- busy  output  1  high from first bit through done cycle
- done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset: synchronous, active-high, highest priority. The next edge with rst=1 forces the following:
  - state=IDLE
  - out=0, valid=0, busy=0, done=0
  - internal shift register, bit counter, repeat counter and gap counter all cleared
- Reset applies mid-transmission; the partial pattern is abandoned with no done pulse.
- Moore FSM. All outputs are registered and are functions of state/datapath only. States:
  - IDLE: out=0, valid=0, busy=0. On an edge with start=1:
    - latch sel_pat = (use_def ? DEF_PAT : pattern)
    - latch rpt_left=rpt, gap_len=gap
    - bit_idx=WIDTH-1
    - go to SHIFT
  - SHIFT: out=sel_pat[bit_idx], valid=1, busy=1.
    - bit_idx>0: decrement, stay.
    - bit_idx==0 and rpt_left>0: decrement rpt_left and reload bit_idx=WIDTH-1.
      - gap_len==0: stay in SHIFT (back-to-back copies).
      - otherwise: gap_cnt=gap_len-1, go to GAP.
    - bit_idx==0 and rpt_left==0: go to DONE.
  - GAP: out=0, valid=0, busy=1. Exits to SHIFT when gap_cnt==0, else decrement. Lasts exactly gap_len cycles.
  - DONE: out=0, valid=0, busy=1, done=1 for exactly one cycle, then IDLE.
- Latency: start high at edge k -> first bit visible after edge k, i.e. during cycle k+1.
- Single copy occupies WIDTH SHIFT cycles + 1 DONE cycle.
- Total busy cycles = (rpt+1)*WIDTH + rpt*gap + 1.
- start outside IDLE is ignored (no queueing); start held high through DONE retriggers on the first IDLE edge.
- pattern/use_def/rpt/gap changes after the start edge have no effect on the current transmission.
- rpt and gap at all-ones are legal: 16 copies and 15-cycle gaps with RPT_W=GAP_W=4. Counters must not wrap.

Test Plan:
- rst=1 two edges, then start=1 one cycle, use_def=1, rpt=0, gap=0 -> out=1,0,1,1 with valid=1 for 4 cycles starting the cycle after start; done=1 on cycle 5; busy high cycles 1-5; then idle with out=0.
- use_def=0, pattern=4'b0110, rpt=1, gap=2 -> out sequence 0,1,1,0,(gap)0,0,0,1,1,0; valid=1,1,1,1,0,0,1,1,1,1; done after 10th cycle; busy=11 cycles.
- DEF_PAT, rpt=1, gap=0, out looped into moore_1011detec -> out=1,0,1,1,1,0,1,1 back-to-back; detector out asserts exactly twice (non-overlapping).
- start pulsed again during SHIFT and GAP with a different pattern -> ignored; original stream unchanged; single done pulse.
- rst asserted during 3rd bit of 1011 -> next cycle out=0, valid=0, busy=0, no done; subsequent start sends a full clean 1011.
- rpt=4'hF, gap=4'hF, pattern 4'b1001 -> 16 copies, 15 zero-cycles between each; busy = 16*4+15*15+1 = 290 cycles; exactly one done.
